// File: rtl/div_nxm_seq_pkg.sv
// Shared definitions for the sequential unsigned N/M restoring divider:
// FSM state encodings and the operand-width legality rule.
package div_nxm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal operand widths, shared with the companion NxM multiplier.
  function automatic bit widths_ok(input int n, input int m);
    return (n >= 2) && (n <= 32) && (m >= 1) && (m <= n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and shift the quotient bit into Q.
module div_step #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic [M:0]   p,
  input  logic [N-1:0] q,
  input  logic [M-1:0] divisor,
  output logic [M:0]   p_next,
  output logic [N-1:0] q_next
);

  logic [M:0] trial;
  logic [M:0] dvs_ext;
  logic       fits;

  always_comb begin
    trial   = {p[M-1:0], q[N-1]};
    dvs_ext = {1'b0, divisor};
    // A carry held in P means the trial value already exceeds any M-bit divisor.
    fits    = p[M] || (trial >= dvs_ext);
    p_next  = fits ? (trial - dvs_ext) : trial;
    q_next  = {q[N-2:0], fits};
  end

endmodule

// File: rtl/div_nxm_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and results held until the next accepted start.
module div_nxm_seq
  import div_nxm_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         dbz
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (!widths_ok(N, M)) begin : g_bad_widths
    $error("div_nxm_seq: illegal widths N=%0d M=%0d (need 2<=N<=32, 1<=M<=N)", N, M);
  end

  state_t        state_q, state_d;
  logic [M:0]    p_q, p_nxt;
  logic [N-1:0]  q_q, q_nxt;
  logic [M-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          div_zero;
  logic          last_step;

  assign div_zero  = (divisor == '0);
  assign last_step = (cnt_q == '0);

  div_step #(
    .N (N),
    .M (M)
  ) u_step (
    .p       (p_q),
    .q       (q_q),
    .divisor (dvs_q),
    .p_next  (p_nxt),
    .q_next  (q_nxt)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Working registers and result registers; results load on the edge that
  // enters DONE so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!div_zero) begin
              p_q   <= '0;
              q_q   <= dividend;
              dvs_q <= divisor;
              cnt_q <= CNT_LAST;
            end else begin
              quotient  <= '1;
              remainder <= dividend[M-1:0];
              dbz       <= 1'b1;
            end
          end
        end
        RUN: begin
          p_q <= p_nxt;
          q_q <= q_nxt;
          if (last_step) begin
            quotient  <= q_nxt;
            remainder <= p_nxt[M-1:0];
            dbz       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_div_nxm_seq.sv
// Directed and randomized checks of div_nxm_seq (N=8, M=4) against an
// arithmetic reference model of unsigned division.
module tb_div_nxm_seq;

  localparam int N       = 8;
  localparam int M       = 4;
  localparam int LAT_MAX = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         dbz;

  int n_cmp  = 0;
  int n_fail = 0;

  // Results the DUT is expected to be holding between operations.
  logic [N-1:0] held_q;
  logic [M-1:0] held_r;
  logic         held_dbz;

  always #5 clk = ~clk;

  div_nxm_seq #(
    .N (N),
    .M (M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [N-1:0] a, input logic [M-1:0] d,
                       output logic [N-1:0] q, output logic [M-1:0] r, output logic z);
    if (d == 0) begin
      q = '1;
      r = a[M-1:0];
      z = 1'b1;
    end else begin
      q = N'(a / d);
      r = M'(a % d);
      z = 1'b0;
    end
  endtask

  // Drives one start right after an edge, then follows it to done and one
  // cycle beyond. Latency counts edges from that point to the done cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] d,
                        input string tag, input bit poke_done);
    logic [N-1:0] eq;
    logic [M-1:0] er;
    logic         ez;
    int           lat;
    int           busy_cnt;
    int           exp_lat;
    model(a, d, eq, er, ez);
    exp_lat  = (d == 0) ? 1 : N + 1;
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) begin
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = M'($urandom);
        if (exp_lat > 1) begin
          check({tag, "_held_q"}, quotient, held_q);
          check({tag, "_held_r"}, remainder, held_r);
        end
      end
      if (busy === 1'b1) busy_cnt++;
    end while (done !== 1'b1 && lat < LAT_MAX);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, dbz, ez);
    if (d != 0) begin
      check({tag, "_q*d+r"}, 32'(quotient) * 32'(d) + 32'(remainder), 32'(a));
      check({tag, "_r<d"}, remainder < d, 1);
    end
    held_q   = eq;
    held_r   = er;
    held_dbz = ez;
    if (poke_done) begin
      dividend = 100;
      divisor  = 3;
      start    = 1'b1;
    end
    tick;
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold_q"}, quotient, held_q);
    if (poke_done) begin
      tick;
      check({tag, "_done_start_ignored"}, busy, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           done_cnt;
    int           done_lat;
    logic [N-1:0] q_at_done;
    logic [M-1:0] r_at_done;
    logic [N-1:0] ra;
    logic [M-1:0] rd;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    held_q   = '0;
    held_r   = '0;
    held_dbz = 1'b0;

    repeat (3) tick;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", dbz, 0);

    // rst dominates a simultaneous start.
    dividend = 200;
    divisor  = 7;
    start    = 1'b1;
    tick;
    check("rst_wins_busy", busy, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick;
    check("rst_wins_idle", busy, 0);

    run_op(8'd200, 4'd7, "op200_7", 1'b0);
    check("op200_7_const_q", held_q, 28);
    check("op200_7_const_r", held_r, 4);
    run_op(8'd255, 4'd15, "op255_15", 1'b0);
    run_op(8'd5, 4'd9, "op5_9_b2b", 1'b1);
    run_op(8'hA6, 4'd0, "opA6_0", 1'b0);
    check("opA6_0_const_q", held_q, 8'hFF);
    check("opA6_0_const_r", held_r, 6);

    // Extra starts during RUN cycles 2 and 5 must be ignored.
    dividend  = 200;
    divisor   = 7;
    start     = 1'b1;
    done_cnt  = 0;
    done_lat  = 0;
    q_at_done = '0;
    r_at_done = '0;
    for (int c = 1; c <= 16; c++) begin
      tick;
      start = (c == 2 || c == 5);
      if (start) begin
        dividend = 100;
        divisor  = 3;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_lat  = c;
        q_at_done = quotient;
        r_at_done = remainder;
      end
    end
    start = 1'b0;
    check("ignore_done_count", done_cnt, 1);
    check("ignore_latency", done_lat, N + 1);
    check("ignore_quotient", q_at_done, 28);
    check("ignore_remainder", r_at_done, 4);
    check("ignore_idle_after", busy, 0);
    held_q = 28;
    held_r = 4;

    // Reset during RUN cycle 4 aborts with no done pulse.
    dividend = 200;
    divisor  = 7;
    start    = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", dbz, 0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    held_q   = '0;
    held_r   = '0;
    held_dbz = 1'b0;
    run_op(8'd9, 4'd2, "op9_2", 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom_range(0, (1 << N) - 1));
      rd = M'($urandom_range(0, (1 << M) - 1));
      if (i % 50 == 0) rd = 1;
      if (i % 50 == 1) ra = 0;
      if (i % 50 == 2) begin
        ra = '1;
        rd = 1;
      end
      run_op(ra, rd, $sformatf("rnd%0d_%0d_%0d", i, ra, rd), (i % 97 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
